// File: rtl/axi_slice.sv
// Valid/ready register slice with selectable timing cut (bypass, forward, skid, full).
// Provides synchronous flush, occupancy status and optional masking of idle output data.
module axi_slice #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned MODE       = 1,
    parameter bit          MASK_DATA  = 1'b1
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  flush,
    input  logic                  pin_valid,
    input  logic [DATA_WIDTH-1:0] pin_data,
    output logic                  pin_ready,
    output logic                  pout_valid,
    output logic [DATA_WIDTH-1:0] pout_data,
    input  logic                  pout_ready,
    output logic [1:0]            occupancy
);

    logic                  w_pout_valid;
    logic [DATA_WIDTH-1:0] w_data_sel;
    logic                  w_xfer_in;
    logic                  w_xfer_out;

    assign w_xfer_in  = pin_valid & pin_ready;
    assign w_xfer_out = w_pout_valid & pout_ready;
    assign pout_valid = w_pout_valid;
    assign pout_data  = MASK_DATA ? (w_data_sel & {DATA_WIDTH{w_pout_valid}}) : w_data_sel;

    if (MODE == 1) begin : g_fwd
        logic                  r_valid;
        logic [DATA_WIDTH-1:0] r_data;

        assign pin_ready    = (~r_valid | pout_ready) & ~flush;
        assign w_pout_valid = r_valid & ~flush;
        assign w_data_sel   = r_data;
        assign occupancy    = {1'b0, r_valid};

        always_ff @(posedge clk or negedge rstn) begin
            if (!rstn)           r_valid <= 1'b0;
            else if (flush)      r_valid <= 1'b0;
            else if (w_xfer_in)  r_valid <= 1'b1;
            else if (w_xfer_out) r_valid <= 1'b0;
        end

        always_ff @(posedge clk) begin
            if (w_xfer_in) r_data <= pin_data;
        end
    end else if (MODE == 2) begin : g_skid
        logic                  r_skid_valid;
        logic [DATA_WIDTH-1:0] r_skid_data;

        assign pin_ready    = ~r_skid_valid & ~flush;
        assign w_pout_valid = (pin_valid | r_skid_valid) & ~flush;
        assign w_data_sel   = r_skid_valid ? r_skid_data : pin_data;
        assign occupancy    = {1'b0, r_skid_valid};

        // An accepted word that the sink refuses parks in the skid; pin_ready
        // is then low, so the skid cannot be overwritten while occupied.
        always_ff @(posedge clk or negedge rstn) begin
            if (!rstn)                          r_skid_valid <= 1'b0;
            else if (flush)                     r_skid_valid <= 1'b0;
            else if (r_skid_valid & pout_ready) r_skid_valid <= 1'b0;
            else if (w_xfer_in & ~pout_ready)   r_skid_valid <= 1'b1;
        end

        always_ff @(posedge clk) begin
            if (w_xfer_in & ~pout_ready) r_skid_data <= pin_data;
        end
    end else if (MODE == 3) begin : g_full
        logic [DATA_WIDTH-1:0] r_mem [2];
        logic                  r_wr_ptr;
        logic                  r_rd_ptr;
        logic [1:0]            r_count;

        assign pin_ready    = (r_count != 2'd2) & ~flush;
        assign w_pout_valid = (r_count != 2'd0) & ~flush;
        assign w_data_sel   = r_mem[r_rd_ptr];
        assign occupancy    = r_count;

        always_ff @(posedge clk or negedge rstn) begin
            if (!rstn) begin
                r_wr_ptr <= 1'b0;
                r_rd_ptr <= 1'b0;
                r_count  <= '0;
            end else if (flush) begin
                r_wr_ptr <= 1'b0;
                r_rd_ptr <= 1'b0;
                r_count  <= '0;
            end else begin
                if (w_xfer_in)  r_wr_ptr <= ~r_wr_ptr;
                if (w_xfer_out) r_rd_ptr <= ~r_rd_ptr;
                case ({w_xfer_in, w_xfer_out})
                    2'b10:   r_count <= r_count + 2'd1;
                    2'b01:   r_count <= r_count - 2'd1;
                    default: r_count <= r_count;
                endcase
            end
        end

        always_ff @(posedge clk) begin
            if (w_xfer_in) r_mem[r_wr_ptr] <= pin_data;
        end
    end else begin : g_bypass
        logic w_unused;

        assign w_unused     = ^{clk, rstn, flush, w_xfer_in, w_xfer_out};
        assign pin_ready    = pout_ready;
        assign w_pout_valid = pin_valid;
        assign w_data_sel   = pin_data;
        assign occupancy    = '0;
    end

endmodule

// File: tb/tb_axi_slice.sv
// Directed bench for axi_slice: one instance per MODE sharing the same stimulus,
// each scenario checks the instance it targets against hand-computed values.
module tb_axi_slice;

    logic        clk = 1'b0;
    logic        rstn;
    logic        flush;
    logic        pin_valid;
    logic [31:0] pin_data;
    logic        pout_ready;
    logic        pr  [4];
    logic        pv  [4];
    logic [31:0] pd  [4];
    logic [1:0]  occ [4];

    int n_total = 0;
    int n_bad   = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 4; g++) begin : g_dut
        axi_slice #(.DATA_WIDTH(32), .MODE(g), .MASK_DATA(1'b1)) u_dut (
            .clk        (clk),
            .rstn       (rstn),
            .flush      (flush),
            .pin_valid  (pin_valid),
            .pin_data   (pin_data),
            .pin_ready  (pr[g]),
            .pout_valid (pv[g]),
            .pout_data  (pd[g]),
            .pout_ready (pout_ready),
            .occupancy  (occ[g])
        );
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
        end
    endtask

    // advance one clock and land 1 time unit after the rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] d, input logic r, input logic f);
        pin_valid  = v;
        pin_data   = d;
        pout_ready = r;
        flush      = f;
        #1;
    endtask

    task automatic do_reset();
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        rstn = 1'b0;
        tick();
        rstn = 1'b1;
        #1;
    endtask

    logic [31:0] seq [3];

    initial begin
        rstn = 1'b0;
        drive(1'b0, 32'h0, 1'b0, 1'b0);

        // Reset state
        #2;
        for (int m = 0; m < 4; m++) begin
            chk($sformatf("rst_pv_m%0d", m), {31'b0, pv[m]}, 32'd0);
            chk($sformatf("rst_occ_m%0d", m), {30'b0, occ[m]}, 32'd0);
            chk($sformatf("rst_pd_m%0d", m), pd[m], 32'd0);
        end
        for (int m = 1; m < 4; m++) chk($sformatf("rst_pr_m%0d", m), {31'b0, pr[m]}, 32'd1);
        chk("rst_pr_m0", {31'b0, pr[0]}, 32'd0);
        tick();
        rstn = 1'b1;
        #1;

        // MODE 0 passthrough, flush ignored
        drive(1'b1, 32'h1234, 1'b0, 1'b1);
        chk("m0_pv", {31'b0, pv[0]}, 32'd1);
        chk("m0_pd", pd[0], 32'h1234);
        chk("m0_pr", {31'b0, pr[0]}, 32'd0);
        drive(1'b0, 32'h1234, 1'b1, 1'b0);
        chk("m0_pv_idle", {31'b0, pv[0]}, 32'd0);
        chk("m0_pd_mask", pd[0], 32'd0);
        chk("m0_pr_rdy", {31'b0, pr[0]}, 32'd1);

        // MODE 1 back-to-back streaming, latency 1
        do_reset();
        seq[0] = 32'h1; seq[1] = 32'h2; seq[2] = 32'h3;
        drive(1'b1, seq[0], 1'b1, 1'b0);
        chk("m1_first_pr", {31'b0, pr[1]}, 32'd1);
        chk("m1_first_pv", {31'b0, pv[1]}, 32'd0);
        tick();
        for (int i = 1; i < 4; i++) begin
            drive(i < 3, (i < 3) ? seq[i] : 32'h0, 1'b1, 1'b0);
            chk($sformatf("m1_pv_%0d", i), {31'b0, pv[1]}, 32'd1);
            chk($sformatf("m1_pd_%0d", i), pd[1], seq[i-1]);
            chk($sformatf("m1_occ_%0d", i), {30'b0, occ[1]}, 32'd1);
            chk($sformatf("m1_pr_%0d", i), {31'b0, pr[1]}, 32'd1);
            tick();
        end
        #1;
        chk("m1_drain_pv", {31'b0, pv[1]}, 32'd0);
        chk("m1_drain_occ", {30'b0, occ[1]}, 32'd0);

        // MODE 2 skid capture and release
        do_reset();
        drive(1'b1, 32'hA, 1'b1, 1'b0);
        chk("m2_a_pv", {31'b0, pv[2]}, 32'd1);
        chk("m2_a_pd", pd[2], 32'hA);
        chk("m2_a_occ", {30'b0, occ[2]}, 32'd0);
        tick();
        drive(1'b1, 32'hB, 1'b0, 1'b0);
        chk("m2_b_pr", {31'b0, pr[2]}, 32'd1);
        chk("m2_b_pd", pd[2], 32'hB);
        tick();
        drive(1'b0, 32'hC, 1'b0, 1'b0);
        chk("m2_skid_pr", {31'b0, pr[2]}, 32'd0);
        chk("m2_skid_pv", {31'b0, pv[2]}, 32'd1);
        chk("m2_skid_pd", pd[2], 32'hB);
        chk("m2_skid_occ", {30'b0, occ[2]}, 32'd1);
        tick();
        drive(1'b1, 32'hC, 1'b1, 1'b0);
        chk("m2_rel_pd", pd[2], 32'hB);
        chk("m2_rel_pr", {31'b0, pr[2]}, 32'd0);
        tick();
        drive(1'b0, 32'hC, 1'b1, 1'b0);
        chk("m2_after_pr", {31'b0, pr[2]}, 32'd1);
        chk("m2_after_occ", {30'b0, occ[2]}, 32'd0);
        chk("m2_after_pd", pd[2], 32'd0);

        // MODE 3 fill to 2, stall upstream, then drain in order
        do_reset();
        drive(1'b1, 32'h11, 1'b0, 1'b0);
        chk("m3_p1_pr", {31'b0, pr[3]}, 32'd1);
        chk("m3_p1_pv", {31'b0, pv[3]}, 32'd0);
        tick();
        drive(1'b1, 32'h22, 1'b0, 1'b0);
        chk("m3_p2_pr", {31'b0, pr[3]}, 32'd1);
        chk("m3_p2_pd", pd[3], 32'h11);
        tick();
        drive(1'b1, 32'h33, 1'b0, 1'b0);
        chk("m3_full_pr", {31'b0, pr[3]}, 32'd0);
        chk("m3_full_occ", {30'b0, occ[3]}, 32'd2);
        tick();
        drive(1'b1, 32'h33, 1'b1, 1'b0);
        chk("m3_stall_occ", {30'b0, occ[3]}, 32'd2);
        chk("m3_out0", pd[3], 32'h11);
        tick();
        drive(1'b1, 32'h33, 1'b1, 1'b0);
        chk("m3_out1", pd[3], 32'h22);
        chk("m3_out1_pr", {31'b0, pr[3]}, 32'd1);
        tick();
        drive(1'b0, 32'h0, 1'b1, 1'b0);
        chk("m3_out2", pd[3], 32'h33);
        chk("m3_out2_occ", {30'b0, occ[3]}, 32'd1);
        tick();
        chk("m3_empty_pv", {31'b0, pv[3]}, 32'd0);

        // MODE 3 steady push+pop at occupancy 1 across pointer wrap
        do_reset();
        drive(1'b1, 32'h40, 1'b0, 1'b0);
        tick();
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 32'h41 + i, 1'b1, 1'b0);
            chk($sformatf("m3_wrap_occ_%0d", i), {30'b0, occ[3]}, 32'd1);
            chk($sformatf("m3_wrap_pd_%0d", i), pd[3], 32'h40 + i);
            tick();
        end
        drive(1'b0, 32'h0, 1'b1, 1'b0);
        chk("m3_wrap_last", pd[3], 32'h48);
        tick();
        chk("m3_wrap_empty", {30'b0, occ[3]}, 32'd0);

        // Flush with MODE 3 at 2 entries and MODE 1 at 1 entry
        do_reset();
        drive(1'b1, 32'h55, 1'b0, 1'b0);
        tick();
        drive(1'b1, 32'h66, 1'b0, 1'b0);
        tick();
        drive(1'b1, 32'h77, 1'b1, 1'b1);
        chk("fl_m3_pv", {31'b0, pv[3]}, 32'd0);
        chk("fl_m3_pr", {31'b0, pr[3]}, 32'd0);
        chk("fl_m3_pd", pd[3], 32'd0);
        chk("fl_m1_pv", {31'b0, pv[1]}, 32'd0);
        chk("fl_m1_pr", {31'b0, pr[1]}, 32'd0);
        tick();
        drive(1'b1, 32'h77, 1'b0, 1'b0);
        chk("fl_m3_occ", {30'b0, occ[3]}, 32'd0);
        chk("fl_m1_occ", {30'b0, occ[1]}, 32'd0);
        chk("fl_m3_pv_after", {31'b0, pv[3]}, 32'd0);
        tick();
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        chk("fl_m3_new", pd[3], 32'h77);
        chk("fl_m1_new", pd[1], 32'h77);
        chk("fl_m3_new_occ", {30'b0, occ[3]}, 32'd1);

        // Asynchronous reset while holding data
        do_reset();
        drive(1'b1, 32'h99, 1'b0, 1'b0);
        tick();
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        chk("ar_pre_occ3", {30'b0, occ[3]}, 32'd1);
        #2;
        rstn = 1'b0;
        #1;
        for (int m = 1; m < 4; m++) begin
            chk($sformatf("ar_pv_m%0d", m), {31'b0, pv[m]}, 32'd0);
            chk($sformatf("ar_pd_m%0d", m), pd[m], 32'd0);
            chk($sformatf("ar_occ_m%0d", m), {30'b0, occ[m]}, 32'd0);
        end
        #1;
        rstn = 1'b1;
        #1;
        for (int m = 1; m < 4; m++) chk($sformatf("ar_pr_m%0d", m), {31'b0, pr[m]}, 32'd1);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
